// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
//   Once per frame, at the first non-visible line, runs up to four update
//   tasks in ascending index order. Each task gets a one-cycle start pulse
//   and is then waited on until it reports done or its wait budget runs
//   out. If the visible region restarts before the sequence finishes, the
//   frame is abandoned and flagged.
//
// Ports
//   clk          pixel clock, shared with the sync generator
//   rst_n        synchronous active-low reset
//   hpos, vpos   horizontal / vertical counters from the sync generator
//   en           scheduler enable; triggers are ignored while low
//   task_mask    bit i enables task i; sampled at the trigger
//   done         per-task completion pulse; only the active task's bit counts
//   clear_flags  single-cycle pulse clearing overrun and timeout_flag
//   start        one-hot, single-cycle start pulse to task i
//   active_task  index of the task in START/WAIT, 0 otherwise
//   busy         high whenever the scheduler is not idle
//   frame_done   single-cycle pulse when all enabled tasks of a frame finish
//   frame_cnt    count of accepted triggers (wraps)
//   overrun      sticky: frame aborted because the visible region restarted
//   timeout_flag sticky: at least one task abandoned by timeout
module frame_update_scheduler #(
  parameter int V_DISPLAY = 480,
  parameter int NUM_TASKS = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       en,
  input  logic [3:0] task_mask,
  input  logic [3:0] done,
  input  logic       clear_flags,
  output logic [3:0] start,
  output logic [1:0] active_task,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       overrun,
  output logic       timeout_flag
);

  // Lanes beyond NUM_TASKS are never scheduled.
  localparam logic [3:0] LANES = (NUM_TASKS >= 4) ? 4'hF : 4'((1 << NUM_TASKS) - 1);
  localparam int         TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The wait budget expires in the cycle the counter would step to TIMEOUT,
  // so the next start lands TIMEOUT+1 cycles after the abandoned one.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  state_t          state, state_d;
  logic [1:0]      task_d;
  logic [3:0]      mask_q, mask_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [3:0]      start_d;
  logic            busy_d, frame_done_d, overrun_d, timeout_d;
  logic [7:0]      cnt_d;

  logic            trigger, wrap, accept;
  logic            done_hit, tmo_hit, advance;
  logic [2:0]      first, nxt;

  // Lowest set bit of m at or above index lo, as {valid, index}.
  function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] lo);
    logic [2:0] sel;
    sel = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (m[i-1] && (3'(i - 1) >= lo)) sel = {1'b1, 2'(i - 1)};
    end
    return sel;
  endfunction

  assign trigger  = (vpos == 10'(V_DISPLAY)) && (hpos == '0);
  assign wrap     = (vpos == '0) && (hpos == '0);
  assign accept   = (state == ST_IDLE) && trigger && en;
  assign done_hit = done[active_task];
  assign tmo_hit  = (tcnt == TLAST);
  assign advance  = done_hit || tmo_hit;
  assign first    = pick(task_mask & LANES, 3'd0);
  assign nxt      = pick(mask_q, {1'b0, active_task} + 3'd1);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      tcnt         <= '0;
      start        <= '0;
      active_task  <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      overrun      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      tcnt         <= tcnt_d;
      start        <= start_d;
      active_task  <= task_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      frame_cnt    <= cnt_d;
      overrun      <= overrun_d;
      timeout_flag <= timeout_d;
    end
  end

  // Next state and next task index
  always_comb begin
    state_d = state;
    task_d  = active_task;
    case (state)
      ST_IDLE: begin
        if (accept && first[2]) begin
          state_d = ST_START;
          task_d  = first[1:0];
        end
      end
      ST_START: begin
        state_d = wrap ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // A visible-region restart outranks done and timeout.
        if (wrap) begin
          state_d = ST_IDLE;
        end else if (advance) begin
          if (nxt[2]) begin
            state_d = ST_START;
            task_d  = nxt[1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) task_d = '0;
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    start_d = '0;
    if (state_d == ST_START) start_d[task_d] = 1'b1;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (accept && !first[2]) ||
                   ((state == ST_WAIT) && !wrap && advance && !nxt[2]);
    cnt_d        = accept ? frame_cnt + 8'd1 : frame_cnt;
    mask_d       = accept ? (task_mask & LANES) : mask_q;
    tcnt_d       = (state == ST_WAIT) ? tcnt + TW'(1) : '0;
    overrun_d    = ((state != ST_IDLE) && wrap) || (overrun && !clear_flags);
    timeout_d    = ((state == ST_WAIT) && !wrap && tmo_hit && !done_hit) ||
                   (timeout_flag && !clear_flags);
  end

endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter V_DISPLAY, default 480, first non-visible line; trigger line.
REQ-002 Parameter NUM_TASKS, default 4, number of sequenced update tasks (fixed at 4 for width purposes).
REQ-003 Parameter TIMEOUT, default 1023, max cycles a task may hold WAIT before being abandoned.
REQ-004 clk  input  1  pixel clock, shared with the sync generator.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 hpos  input  10  horizontal counter from the sync generator.
REQ-007 vpos  input  10  vertical counter from the sync generator.
REQ-008 en  input  1  scheduler enable; triggers are ignored when low.
REQ-009 task_mask  input  4  bit i high enables task i; sampled at trigger.
REQ-010 done  input  4  task i completion pulse; only the active task's bit is honoured.
REQ-011 clear_flags  input  1  single-cycle pulse clearing sticky flags.
REQ-012 start  output  4  one-hot, single-cycle start pulse to task i.
REQ-013 active_task  output  2  index of the task in START/WAIT, 0 otherwise.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 frame_done  output  1  single-cycle pulse when all enabled tasks of a frame finish.
REQ-016 frame_cnt  output  8  count of accepted triggers, wraps 255->0.
REQ-017 overrun  output  1  sticky: frame aborted because visible region restarted.
REQ-018 timeout_flag  output  1  sticky: at least one task abandoned by timeout.

Function
REQ-019 Trigger is asserted for exactly one cycle, when vpos==V_DISPLAY and hpos==0.
REQ-020 Wrap event is asserted for one cycle, when vpos==0 and hpos==0.
REQ-021 FSM states: IDLE, START, WAIT; state is registered and all outputs are registered.
REQ-022 IDLE: on trigger with en=1, latch task_mask, increment frame_cnt, then go to START for the lowest set mask bit, or pulse frame_done and stay IDLE if the latched mask is 0.
REQ-023 IDLE: a trigger with en=0 changes nothing, including frame_cnt.
REQ-024 Latency: trigger in cycle T; start[k] for the first enabled task is high in cycle T+1 only.
REQ-025 START lasts one cycle (start[active_task]=1), then WAIT; the timeout counter clears to 0 on entering WAIT.
REQ-026 WAIT: done[active_task] in cycle D selects the next higher enabled task, whose start is high at D+1; if none remains, frame_done is high at D+1 and the FSM returns to IDLE.
REQ-027 WAIT: the timeout counter increments each cycle; when it reaches TIMEOUT without a done, set timeout_flag and advance exactly as for done.
REQ-028 If done and timeout occur in the same cycle, done wins and timeout_flag is not set.
REQ-029 done bits other than done[active_task] are ignored in every state.
REQ-030 A wrap event while busy aborts to IDLE next cycle: no start pulse, no frame_done, overrun set; the abort takes priority over done and timeout in the same cycle.
REQ-031 A trigger while busy (impossible with a legal sync generator) is ignored.
REQ-032 clear_flags clears overrun and timeout_flag; a set event in the same cycle wins.
REQ-033 start is all-zero except in START; at most one bit is ever high.

Reset
REQ-034 rst_n=0 at a clk edge forces state IDLE, and sets start, active_task, busy, frame_done, frame_cnt, overrun, timeout_flag and the timeout counter to 0; the latched mask is also cleared.
REQ-035 Reset mid-frame abandons the sequence silently: no frame_done and no flag set.

Verification
REQ-036 en=1, mask=4'b1111, each done returns 5 cycles after its start -> start bits 0,1,2,3 pulse in order, frame_done at last-done+1, frame_cnt=1.
REQ-037 mask=4'b1010 -> only start[1] then start[3]; mask=0 -> frame_done at T+1 with no starts.
REQ-038 Task 2 never returns done, TIMEOUT=1023 -> start[3] issued 1024 cycles after start[2], timeout_flag=1; then clear_flags -> 0.
REQ-039 Task 1 is still waiting when vpos=0,hpos=0 -> busy falls next cycle, overrun=1, no frame_done; the next frame still sequences normally.
REQ-040 Run 256 frames -> frame_cnt wraps to 0; assert rst_n=0 mid-WAIT -> all outputs 0 next cycle.
